// File: rtl/uop_dispatch_if.sv
// Interface between the dispatch stage, the uop queue in front of it and the
// execute stage behind it. The dispatch stage uses the master modport; the
// surrounding environment (queue + execute + pipeline control) uses slave.
interface uop_dispatch_if #(
    parameter int UOP_W = 64,
    parameter int N     = 2,
    parameter int CNT_W = 5
);

    // Queue side
    logic [CNT_W-1:0]   q_elements;
    logic               get_uop;
    logic [N*UOP_W-1:0] q_uop;

    // Execute side
    logic               exe_valid;
    logic               exe_ready;
    logic [UOP_W-1:0]   exe_uop;

    // Pipeline control and status
    logic               flush;
    logic               busy;
    logic [31:0]        dispatch_count;

    modport master (
        input  q_elements,
        input  q_uop,
        input  exe_ready,
        input  flush,
        output get_uop,
        output exe_valid,
        output exe_uop,
        output busy,
        output dispatch_count
    );

    modport slave (
        output q_elements,
        output q_uop,
        output exe_ready,
        output flush,
        input  get_uop,
        input  exe_valid,
        input  exe_uop,
        input  busy,
        input  dispatch_count
    );

endinterface

// File: rtl/uop_dispatch.sv
// Single-issue dispatch stage. Pulls bundles of up to N uops from the uop
// queue into a local bundle buffer and hands them to execute one per cycle,
// oldest first. A new bundle is requested in the same cycle the last buffered
// uop is accepted, so consecutive bundles dispatch without a bubble.
module uop_dispatch #(
    parameter int UOP_W = 64,
    parameter int N     = 2,
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              reset,   // asynchronous, active-low
    uop_dispatch_if.master    bus
);

    // Index into the bundle buffer and fill level (0..N) of the buffer.
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int FILL_W = $clog2(N + 1);

    // The control state is fully determined by the fill level; this enum is
    // the decoded view used by the output logic.
    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_e;

    logic [UOP_W-1:0]  buf_q [N];
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [FILL_W-1:0] cnt_q, cnt_d;
    logic [31:0]       dispatch_count_q, dispatch_count_d;

    state_e            state;
    logic              fire;
    logic              last;
    logic              refill;
    logic [FILL_W-1:0] take;

    // Decode state, handshake and refill request from the current fill level.
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state  = (cnt_q != '0) ? DRAIN : EMPTY;
        fire   = 1'b0;
        last   = 1'b0;
        refill = 1'b0;
        take   = '0;

        // Uops offered by the queue, capped at one bundle.
        if (bus.q_elements >= CNT_W'(N)) begin
            take = FILL_W'(N);
        end else begin
            take = FILL_W'(bus.q_elements);
        end

        fire = (state == DRAIN) && !bus.flush && bus.exe_ready;
        last = fire && (cnt_q == FILL_W'(1));

        // Request the next bundle when the buffer is empty or is emptying this
        // cycle; never during flush and never while held in reset.
        refill = reset && !bus.flush && (bus.q_elements != '0) &&
                 ((state == EMPTY) || last);
    end

    // Next-state of the fill level, read pointer and dispatch counter.
    // Flush wins over refill, which wins over a plain drain step.
    always_comb begin
        cnt_d            = cnt_q;
        rd_idx_d         = rd_idx_q;
        dispatch_count_d = dispatch_count_q;

        if (fire) begin
            dispatch_count_d = dispatch_count_q + 32'd1;
        end

        if (bus.flush) begin
            cnt_d    = '0;
            rd_idx_d = '0;
        end else if (refill) begin
            cnt_d    = take;
            rd_idx_d = '0;
        end else if (fire) begin
            cnt_d    = cnt_q - FILL_W'(1);
            rd_idx_d = rd_idx_q + IDX_W'(1);
        end
    end

    // Control state register with asynchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q            <= '0;
            rd_idx_q         <= '0;
            dispatch_count_q <= '0;
        end else begin
            cnt_q            <= cnt_d;
            rd_idx_q         <= rd_idx_d;
            dispatch_count_q <= dispatch_count_d;
        end
    end

    // Bundle buffer: capture the offered slots of the queue bundle on refill.
    // NOTE: the data storage has no reset; its contents are only observed
    // while cnt_q marks them valid, so a reset would only cost area.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (refill && (FILL_W'(i) < take)) begin
                buf_q[i] <= bus.q_uop[i*UOP_W +: UOP_W];
            end
        end
    end

    // Outputs. The fill level is cleared asynchronously by reset, so the
    // cnt-derived outputs drop immediately; busy is gated explicitly as well.
    assign bus.get_uop        = refill;
    assign bus.exe_valid      = (state == DRAIN) && !bus.flush;
    assign bus.exe_uop        = buf_q[rd_idx_q];
    assign bus.busy           = reset && (state == DRAIN);
    assign bus.dispatch_count = dispatch_count_q;

endmodule

// File: tb/tb_uop_dispatch.sv
// Self-checking bench for uop_dispatch. A queue-based model of the bundle
// buffer predicts every output each cycle; directed sequences with literal
// expectations pin the model, followed by randomized traffic.
module tb_uop_dispatch;

    localparam int UOP_W = 64;
    localparam int N     = 2;
    localparam int CNT_W = 5;

    logic clk;
    logic reset;

    int n_checks;
    int n_fail;

    // Behavioural model: the uops still waiting, oldest at the front.
    logic [UOP_W-1:0] m_buf[$];
    logic [31:0]      m_count;

    uop_dispatch_if #(.UOP_W(UOP_W), .N(N), .CNT_W(CNT_W)) bus ();

    uop_dispatch #(.UOP_W(UOP_W), .N(N), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge; returns 2 time units
    // later so outputs can be sampled well away from the rising edge.
    task automatic drive(input int qe, input logic [63:0] s0, input logic [63:0] s1,
                         input bit rdy, input bit fl);
        @(negedge clk);
        bus.q_elements = CNT_W'(qe);
        bus.q_uop      = {s1, s0};
        bus.exe_ready  = rdy;
        bus.flush      = fl;
        #2;
    endtask

    // Model update on each rising edge, straight from the dispatch rules.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_buf.delete();
            m_count = 32'd0;
        end else begin
            bit          m_fire;
            bit          m_get;
            int          m_take;
            logic [63:0] m_slot0;
            logic [63:0] m_slot1;
            m_slot0 = bus.q_uop[63:0];
            m_slot1 = bus.q_uop[127:64];
            m_fire  = (m_buf.size() > 0) && !bus.flush && bus.exe_ready;
            m_get   = !bus.flush && (bus.q_elements > 0) &&
                      ((m_buf.size() == 0) || (m_buf.size() == 1 && m_fire));
            m_take  = (int'(bus.q_elements) < N) ? int'(bus.q_elements) : N;
            if (bus.flush) begin
                m_buf.delete();
            end else begin
                if (m_fire) begin
                    void'(m_buf.pop_front());
                    m_count = m_count + 32'd1;
                end
                if (m_get) begin
                    m_buf.delete();
                    if (m_take > 0) m_buf.push_back(m_slot0);
                    if (m_take > 1) m_buf.push_back(m_slot1);
                end
            end
        end
    end

    // Single compare process: every cycle, after the inputs have settled.
    always @(negedge clk) begin
        bit e_valid;
        bit e_get;
        #2;
        e_valid = reset && (m_buf.size() > 0) && !bus.flush;
        e_get   = reset && !bus.flush && (bus.q_elements > 0) &&
                  ((m_buf.size() == 0) ||
                   (m_buf.size() == 1 && bus.exe_ready));
        check("model exe_valid", 64'(bus.exe_valid), 64'(e_valid));
        check("model get_uop", 64'(bus.get_uop), 64'(e_get));
        check("model busy", 64'(bus.busy), 64'(reset && m_buf.size() > 0));
        check("model dispatch_count", 64'(bus.dispatch_count), 64'(m_count));
        if (e_valid) check("model exe_uop", bus.exe_uop, m_buf[0]);
    end

    localparam logic [63:0] UA = 64'hA000_0000_0000_000A;
    localparam logic [63:0] UB = 64'hB000_0000_0000_000B;
    localparam logic [63:0] UC = 64'hC000_0000_0000_000C;
    localparam logic [63:0] UJ = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [63:0] UD = 64'hD000_0000_0000_000D;
    localparam logic [63:0] UE = 64'hE000_0000_0000_000E;
    localparam logic [63:0] UF = 64'hF000_0000_0000_000F;
    localparam logic [63:0] UG = 64'h6000_0000_0000_0006;
    localparam logic [63:0] UP = 64'h1111_0000_0000_1111;
    localparam logic [63:0] UQ = 64'h2222_0000_0000_2222;
    localparam logic [63:0] UR = 64'h3333_0000_0000_3333;
    localparam logic [63:0] US = 64'h4444_0000_0000_4444;
    localparam logic [63:0] UT = 64'h5555_0000_0000_5555;

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b0;
        bus.q_elements = '0;
        bus.q_uop      = '0;
        bus.exe_ready  = 1'b0;
        bus.flush      = 1'b0;

        repeat (3) @(negedge clk);
        check("reset exe_valid", 64'(bus.exe_valid), 64'd0);
        check("reset get_uop", 64'(bus.get_uop), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset dispatch_count", 64'(bus.dispatch_count), 64'd0);
        reset = 1'b1;

        // Bundle {A,B}, then back-to-back refill with {C,junk} of which only C counts.
        drive(2, UA, UB, 1, 0);
        check("ab get", 64'(bus.get_uop), 64'd1);
        check("ab idle valid", 64'(bus.exe_valid), 64'd0);
        drive(2, UJ, UJ, 1, 0);
        check("a uop", bus.exe_uop, UA);
        check("a get", 64'(bus.get_uop), 64'd0);
        drive(1, UC, UJ, 1, 0);
        check("b uop", bus.exe_uop, UB);
        check("b back-to-back get", 64'(bus.get_uop), 64'd1);
        drive(0, UJ, UJ, 1, 0);
        check("c uop", bus.exe_uop, UC);
        check("count after ab", 64'(bus.dispatch_count), 64'd2);
        drive(0, UJ, UJ, 1, 0);
        check("junk never valid", 64'(bus.exe_valid), 64'd0);
        check("count after c", 64'(bus.dispatch_count), 64'd3);

        // Bundle {D,E} with execute stalled for three cycles.
        drive(2, UD, UE, 0, 0);
        check("de get", 64'(bus.get_uop), 64'd1);
        for (int i = 0; i < 3; i++) begin
            drive(2, UF, UG, 0, 0);
            check("stall valid", 64'(bus.exe_valid), 64'd1);
            check("stall uop", bus.exe_uop, UD);
            check("stall get", 64'(bus.get_uop), 64'd0);
        end
        drive(2, UF, UG, 1, 0);
        check("d uop", bus.exe_uop, UD);
        drive(0, UJ, UJ, 1, 0);
        check("e uop", bus.exe_uop, UE);
        drive(0, UJ, UJ, 1, 0);
        check("count after de", 64'(bus.dispatch_count), 64'd5);

        // Flush while D of {D,E} is presented; E must be dropped.
        drive(2, UD, UE, 1, 0);
        drive(4, UP, UQ, 1, 1);
        check("flush valid", 64'(bus.exe_valid), 64'd0);
        check("flush get", 64'(bus.get_uop), 64'd0);
        check("flush busy", 64'(bus.busy), 64'd1);
        drive(4, UP, UQ, 1, 0);
        check("post flush busy", 64'(bus.busy), 64'd0);
        check("post flush get", 64'(bus.get_uop), 64'd1);
        check("post flush count", 64'(bus.dispatch_count), 64'd5);
        drive(0, UJ, UJ, 1, 0);
        check("p uop", bus.exe_uop, UP);
        drive(0, UJ, UJ, 1, 0);
        check("q uop", bus.exe_uop, UQ);
        drive(0, UJ, UJ, 1, 0);
        check("count after pq", 64'(bus.dispatch_count), 64'd7);

        // Counter wrap: preload both DUT and model to all-ones, then one fire.
        @(negedge clk);
        dut.dispatch_count_q = 32'hFFFF_FFFF;
        m_count              = 32'hFFFF_FFFF;
        drive(1, UR, UJ, 1, 0);
        drive(0, UJ, UJ, 1, 0);
        check("wrap pre", 64'(bus.dispatch_count), 64'hFFFF_FFFF);
        check("r uop", bus.exe_uop, UR);
        drive(0, UJ, UJ, 1, 0);
        check("wrap to zero", 64'(bus.dispatch_count), 64'd0);

        // Asynchronous reset pulse between clock edges while draining.
        drive(2, US, UT, 0, 0);
        drive(0, UJ, UJ, 0, 0);
        check("pre reset valid", 64'(bus.exe_valid), 64'd1);
        #5;
        reset = 1'b0;
        #1;
        check("async reset valid", 64'(bus.exe_valid), 64'd0);
        check("async reset get", 64'(bus.get_uop), 64'd0);
        check("async reset busy", 64'(bus.busy), 64'd0);
        check("async reset count", 64'(bus.dispatch_count), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic with occasional flushes and reset pulses.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int qe;
            qe = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6));
            drive(qe, {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #5;
                reset = 1'b0;
                #1;
                check("rand async reset valid", 64'(bus.exe_valid), 64'd0);
                check("rand async reset busy", 64'(bus.busy), 64'd0);
                @(negedge clk);
                reset = 1'b1;
            end
        end

        drive(0, UJ, UJ, 1, 0);
        drive(0, UJ, UJ, 1, 0);
        drive(0, UJ, UJ, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
